fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV32I core: owns the program counter, issues word reads to the instruction memory, and holds the fetched instruction in an IF/ID output register that feeds the control unit and register file. It sits directly upstream of the control unit. It supports downstream stall, branch redirect/flush, and a variable-latency instruction memory with at most one outstanding request.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  request strobe; one cycle per request.
- imem_addr  out  32  byte address of the requested word; equals pc.
- imem_rvalid  in  1  response valid; one cycle, at least one cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- stall  in  1  downstream cannot accept; the output register holds.
- branch_taken  in  1  one-cycle redirect pulse from execute.
- branch_target  in  32  redirect address, valid with branch_taken.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_instr  out  32  fetched instruction; NOP (32'h0000_0013) when not valid.
- if_pc  out  32  address of if_instr.

## Operation
- States: S_BOOT (reset state), S_REQ, S_WAIT.
- S_BOOT: no request; next edge goes to S_REQ.
- S_REQ: imem_req = 1 only when the output register is free or consumed this cycle (!if_valid || !stall). On a request, go to S_WAIT. Otherwise stay in S_REQ with imem_req = 0.
- S_WAIT: imem_req = 0. On imem_rvalid with drop = 0, load the output register with if_instr = imem_rdata, if_pc = pc, if_valid = 1, and set pc = pc + 4. On imem_rvalid with drop = 1, discard the data and clear drop. In both cases go to S_REQ.
- Consumption: at any edge with if_valid && !stall, the output register is taken. if_valid goes to 0 unless it is reloaded at the same edge.
- Only one request is ever outstanding. When a response arrives, the output register is always free.
- The redirect (branch_taken) has the highest priority, above stall and above a response in the same cycle. At that edge:
  - pc = {branch_target[31:2], 2'b00}, so bits [1:0] are forced to zero.
  - if_valid = 0 and if_instr = NOP.
  - In S_REQ with a request issued that cycle: go to S_WAIT with drop = 1.
  - In S_WAIT without imem_rvalid: drop = 1.
  - In S_WAIT with imem_rvalid: discard the data, drop = 0, go to S_REQ.
  - In S_BOOT: pc is loaded and state proceeds normally.
- Arithmetic: pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.
- imem_rvalid is ignored in S_BOOT and S_REQ. This covers a stale response from before a reset.

## Timing
- Reset values: state = S_BOOT, pc = RESET_PC, drop = 0, if_valid = 0, if_instr = 32'h0000_0013, if_pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC.
- Reset mid-operation: all state is reset immediately (asynchronous). Any outstanding request is abandoned.
- First request: imem_req is high in the second cycle after rst_n deasserts, with imem_addr = RESET_PC.
- Latency: with a 1-cycle memory, if_valid rises 2 cycles after imem_req.
- Throughput: with no stall, 1 instruction per 2 cycles.
- imem_req and imem_addr are combinational from registered state, if_valid and stall. All other outputs are registered.
- Redirect to first new request: 1 cycle when no drop is pending. Otherwise the request follows the cycle after the dropped response.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013;
  - XLEN = 32;
  - the fetch state enum (S_BOOT, S_REQ, S_WAIT);
  - opcode[6:2] constants (R-type 5'b01100, load 5'b00000, store 5'b01000, branch 5'b11000) shared with the control unit.
- One sub-module: pc_unit, which contains the PC register and the next-PC mux (hold / +4 / redirect-aligned). The FSM and the output register stay in fetch_stage.

## Test plan
- Reset release with a 1-cycle memory returning 32'h0000_0033 at 0x0: imem_req at cycle 2, if_valid at cycle 4 with if_pc = 0; the next request is at 0x4.
- Memory returns at 3-cycle latency and stall is held for 5 cycles: if_instr/if_pc stay stable and no new imem_req is issued until stall drops.
- branch_taken with target 32'h0000_0102 while in S_WAIT: the late response is discarded (if_valid stays 0), and the next imem_addr = 0x100.
- branch_taken and imem_rvalid in the same cycle while stalled: if_valid = 0 and if_instr = NOP after the edge; the next request is to the target.
- RESET_PC = 32'hFFFF_FFFC: the first fetch is at 0xFFFF_FFFC and the second at 0x0000_0000.
- rst_n pulsed low while in S_WAIT, followed by a stale imem_rvalid: outputs return to their reset values and the stale data is never presented.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch stage and the control unit.
// Holds the fetch FSM encoding, the canonical NOP and the opcode[6:2] groups.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    // opcode[6:2] groups decoded by the control unit
    localparam logic [4:0] OPC_RTYPE  = 5'b01100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] i_addr);
        return i_addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory handshake, pipeline control and IF/ID output.
// The master side is the fetch stage; the slave side is memory plus the rest of the core.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  stall, branch_taken, branch_target,
        output if_valid, if_instr, if_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output stall, branch_taken, branch_target,
        input  if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection: redirect (word-aligned) over +4 over hold.
// The +4 path wraps modulo 2^32.
module pc_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = align_word(i_target);
        end else if (i_advance) begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem request FSM and the IF/ID register.
// A redirect overrides stall and any same-cycle response; an in-flight response is dropped.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e    r_state;
    logic            r_drop;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic [XLEN-1:0] w_pc;
    logic            w_req;
    logic            w_advance;

    // A request is only issued when the output register will be free to take its response.
    assign w_req     = (r_state == S_REQ) && (!r_if_valid || !bus.stall);
    assign w_advance = (r_state == S_WAIT) && bus.imem_rvalid && !r_drop && !bus.branch_taken;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_redirect (bus.branch_taken),
        .i_target   (bus.branch_target),
        .i_advance  (w_advance),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= RESET_PC;
        end else if (bus.branch_taken) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            case (r_state)
                S_BOOT: r_state <= S_REQ;
                S_REQ: begin
                    if (w_req) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end else begin
            if (r_if_valid && !bus.stall) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
            case (r_state)
                S_BOOT: r_state <= S_REQ;
                S_REQ: begin
                    if (w_req) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_state <= S_REQ;
                        if (r_drop) begin
                            r_drop <= 1'b0;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= bus.imem_rdata;
                            r_if_pc    <= w_pc;
                        end
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, 1- and 3-cycle memory, stall, redirects, PC wrap, mid-run reset.
// The second instance uses RESET_PC = 0xFFFF_FFFC and has its own reset.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    logic rst_w_n;
    int   n_cmp;
    int   n_err;

    fetch_stage_if if_main ();
    fetch_stage_if if_wrap ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_main)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk   (clk),
        .rst_n (rst_w_n),
        .bus   (if_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_main();
        if_main.imem_rvalid   = 1'b0;
        if_main.imem_rdata    = 32'h0;
        if_main.stall         = 1'b0;
        if_main.branch_taken  = 1'b0;
        if_main.branch_target = 32'h0;
    endtask

    // Holds reset for two edges and releases it 2 time units after an edge (cycle 1).
    task automatic boot();
        clear_main();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.if_instr !== NOP_INSTR) begin n_err++; $display("FAIL rst_instr got=%h exp=%h", if_main.if_instr, NOP_INSTR); end
        n_cmp++; if (if_main.if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", if_main.if_pc); end
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%h exp=0", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", if_main.imem_addr); end
        n_cmp++; if (if_wrap.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rst_w_addr got=%h exp=fffffffc", if_wrap.imem_addr); end
        n_cmp++; if (if_wrap.if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rst_w_pc got=%h exp=fffffffc", if_wrap.if_pc); end
    endtask

    task automatic test_basic();
        boot();
        #1;
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_c1 got=%h exp=0", if_main.imem_req); end
        tick();
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req_c2 got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_addr_c2 got=%h exp=0", if_main.imem_addr); end
        tick();
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_c3 got=%h exp=0", if_main.imem_req); end
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0000_0033;
        tick();
        if_main.imem_rvalid = 1'b0; if_main.imem_rdata = 32'h0;
        #1;
        n_cmp++; if (if_main.if_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_c4 got=%h exp=1", if_main.if_valid); end
        n_cmp++; if (if_main.if_pc !== 32'h0) begin n_err++; $display("FAIL basic_pc_c4 got=%h exp=0", if_main.if_pc); end
        n_cmp++; if (if_main.if_instr !== 32'h0000_0033) begin n_err++; $display("FAIL basic_instr_c4 got=%h exp=00000033", if_main.if_instr); end
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req2 got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_addr2 got=%h exp=4", if_main.imem_addr); end
        tick();
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.if_instr !== NOP_INSTR) begin n_err++; $display("FAIL basic_nop got=%h exp=%h", if_main.if_instr, NOP_INSTR); end
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0040_0093;
        tick();
        if_main.imem_rvalid = 1'b0;
        n_cmp++; if (if_main.if_pc !== 32'h4) begin n_err++; $display("FAIL basic_pc2 got=%h exp=4", if_main.if_pc); end
        n_cmp++; if (if_main.if_instr !== 32'h0040_0093) begin n_err++; $display("FAIL basic_instr2 got=%h exp=00400093", if_main.if_instr); end
    endtask

    task automatic test_stall();
        boot();
        tick();
        tick();
        tick();
        tick();
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0020_8133; if_main.stall = 1'b1;
        tick();
        if_main.imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got=%h exp=0", i, if_main.imem_req); end
            n_cmp++; if (if_main.if_pc !== 32'h0) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=0", i, if_main.if_pc); end
            n_cmp++; if (if_main.if_instr !== 32'h0020_8133) begin n_err++; $display("FAIL stall_instr[%0d] got=%h exp=00208133", i, if_main.if_instr); end
            tick();
        end
        if_main.stall = 1'b0;
        #1;
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL stall_release_req got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h4) begin n_err++; $display("FAIL stall_release_addr got=%h exp=4", if_main.imem_addr); end
        tick();
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL stall_consumed got=%h exp=0", if_main.if_valid); end
    endtask

    task automatic test_branch_wait();
        boot();
        tick();
        tick();
        if_main.branch_taken = 1'b1; if_main.branch_target = 32'h0000_0102;
        tick();
        if_main.branch_taken = 1'b0; if_main.branch_target = 32'h0;
        #1;
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL bw_req_wait got=%h exp=0", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h100) begin n_err++; $display("FAIL bw_pc got=%h exp=100", if_main.imem_addr); end
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'hDEAD_BEEF;
        tick();
        if_main.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL bw_dropped_valid got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.if_instr !== NOP_INSTR) begin n_err++; $display("FAIL bw_dropped_instr got=%h exp=%h", if_main.if_instr, NOP_INSTR); end
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL bw_req got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h100) begin n_err++; $display("FAIL bw_addr got=%h exp=100", if_main.imem_addr); end
        tick();
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h00A0_0513;
        tick();
        if_main.imem_rvalid = 1'b0;
        n_cmp++; if (if_main.if_valid !== 1'b1) begin n_err++; $display("FAIL bw_new_valid got=%h exp=1", if_main.if_valid); end
        n_cmp++; if (if_main.if_pc !== 32'h100) begin n_err++; $display("FAIL bw_new_pc got=%h exp=100", if_main.if_pc); end
        n_cmp++; if (if_main.if_instr !== 32'h00A0_0513) begin n_err++; $display("FAIL bw_new_instr got=%h exp=00a00513", if_main.if_instr); end
    endtask

    task automatic test_branch_rvalid_stall();
        boot();
        tick();
        tick();
        if_main.stall = 1'b1;
        if_main.branch_taken = 1'b1; if_main.branch_target = 32'h0000_0200;
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h1111_1111;
        tick();
        if_main.branch_taken = 1'b0; if_main.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL brs_valid got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.if_instr !== NOP_INSTR) begin n_err++; $display("FAIL brs_instr got=%h exp=%h", if_main.if_instr, NOP_INSTR); end
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL brs_req got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h200) begin n_err++; $display("FAIL brs_addr got=%h exp=200", if_main.imem_addr); end
        tick();
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h2222_2222;
        tick();
        if_main.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (if_main.if_pc !== 32'h200) begin n_err++; $display("FAIL brs_fill_pc got=%h exp=200", if_main.if_pc); end
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL brs_full_req got=%h exp=0", if_main.imem_req); end
        if_main.branch_taken = 1'b1; if_main.branch_target = 32'h0000_0307;
        tick();
        if_main.branch_taken = 1'b0;
        #1;
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL brq_valid got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.imem_req !== 1'b1) begin n_err++; $display("FAIL brq_req got=%h exp=1", if_main.imem_req); end
        n_cmp++; if (if_main.imem_addr !== 32'h304) begin n_err++; $display("FAIL brq_addr got=%h exp=304", if_main.imem_addr); end
        if_main.stall = 1'b0;
    endtask

    task automatic test_wrap();
        rst_w_n = 1'b1;
        tick();
        n_cmp++; if (if_wrap.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req1 got=%h exp=1", if_wrap.imem_req); end
        n_cmp++; if (if_wrap.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr1 got=%h exp=fffffffc", if_wrap.imem_addr); end
        tick();
        if_wrap.imem_rvalid = 1'b1; if_wrap.imem_rdata = 32'h0000_0033;
        tick();
        if_wrap.imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (if_wrap.if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ifpc1 got=%h exp=fffffffc", if_wrap.if_pc); end
        n_cmp++; if (if_wrap.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req2 got=%h exp=1", if_wrap.imem_req); end
        n_cmp++; if (if_wrap.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr2 got=%h exp=0", if_wrap.imem_addr); end
        tick();
        if_wrap.imem_rvalid = 1'b1; if_wrap.imem_rdata = 32'h0000_0013;
        tick();
        if_wrap.imem_rvalid = 1'b0;
        n_cmp++; if (if_wrap.if_pc !== 32'h0) begin n_err++; $display("FAIL wrap_ifpc2 got=%h exp=0", if_wrap.if_pc); end
        rst_w_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        boot();
        tick();
        tick();
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0000_0033;
        tick();
        if_main.imem_rvalid = 1'b0;
        tick();
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0000_0044;
        tick();
        if_main.imem_rvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (if_main.imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_addr got=%h exp=0", if_main.imem_addr); end
        n_cmp++; if (if_main.if_pc !== 32'h0) begin n_err++; $display("FAIL rm_ifpc got=%h exp=0", if_main.if_pc); end
        n_cmp++; if (if_main.imem_req !== 1'b0) begin n_err++; $display("FAIL rm_req got=%h exp=0", if_main.imem_req); end
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%h exp=0", if_main.if_valid); end
        tick();
        rst_n = 1'b1;
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'hBAD0_0BAD;
        tick();
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale1_valid got=%h exp=0", if_main.if_valid); end
        if_main.imem_rvalid = 1'b0;
        tick();
        n_cmp++; if (if_main.if_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale2_valid got=%h exp=0", if_main.if_valid); end
        n_cmp++; if (if_main.if_instr !== NOP_INSTR) begin n_err++; $display("FAIL rm_stale2_instr got=%h exp=%h", if_main.if_instr, NOP_INSTR); end
        if_main.imem_rvalid = 1'b1; if_main.imem_rdata = 32'h0000_0033;
        tick();
        if_main.imem_rvalid = 1'b0;
        n_cmp++; if (if_main.if_instr !== 32'h0000_0033) begin n_err++; $display("FAIL rm_instr got=%h exp=00000033", if_main.if_instr); end
        n_cmp++; if (if_main.if_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc got=%h exp=0", if_main.if_pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst_w_n = 1'b0;
        clear_main();
        if_wrap.imem_rvalid   = 1'b0;
        if_wrap.imem_rdata    = 32'h0;
        if_wrap.stall         = 1'b0;
        if_wrap.branch_taken  = 1'b0;
        if_wrap.branch_target = 32'h0;

        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_branch_rvalid_stall();
        test_wrap();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
